// File: rtl/mem_pkg.sv
// Shared types for the posted-write buffer: word layout, buffer entry and
// the word-address compare used by every lookup.
package mem_pkg;

  localparam int WORD_BYTES   = 4;
  localparam int ENTRY_ADDR_W = 32;

  // Byte 0 sits in the most significant position of the packed word.
  typedef logic [0:WORD_BYTES-1][7:0] byte_word_t;

  typedef struct packed {
    logic                    valid;
    logic [ENTRY_ADDR_W-1:0] addr;
    byte_word_t              data;
  } wb_entry_t;

  function automatic logic word_match(input logic [ENTRY_ADDR_W-1:0] a,
                                      input logic [ENTRY_ADDR_W-1:0] b);
    return a[ENTRY_ADDR_W-1:2] == b[ENTRY_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/wb_match.sv
// Parallel word-address compare across all buffer slots. Slots are scanned
// oldest to youngest relative to tail, so the last match seen is the youngest.
module wb_match
  import mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t               entries [DEPTH],
  input  logic [PTR_W-1:0]        tail,
  input  logic [PTR_W-1:0]        head,
  input  logic                    exclude_head,
  input  logic [ENTRY_ADDR_W-1:0] addr,
  output logic                    hit,
  output logic [PTR_W-1:0]        youngest_idx,
  output logic                    coalesce_hit,
  output logic [PTR_W-1:0]        coalesce_idx
);

  // Youngest match overall, and youngest match that is not leaving this cycle
  always_comb begin
    logic [PTR_W-1:0] idx_s;
    logic             match_s;
    logic             coal_ok_s;
    idx_s        = PTR_W'(0);
    match_s      = 1'b0;
    coal_ok_s    = 1'b0;
    hit          = 1'b0;
    youngest_idx = PTR_W'(0);
    coalesce_hit = 1'b0;
    coalesce_idx = PTR_W'(0);
    for (int k = DEPTH; k >= 1; k--) begin
      idx_s        = tail - PTR_W'(k);
      match_s      = entries[idx_s].valid && word_match(entries[idx_s].addr, addr);
      coal_ok_s    = match_s && !(exclude_head && (idx_s == head));
      hit          = hit | match_s;
      youngest_idx = match_s ? idx_s : youngest_idx;
      coalesce_hit = coalesce_hit | coal_ok_s;
      coalesce_idx = coal_ok_s ? idx_s : coalesce_idx;
    end
  end

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write FIFO between the core memory port and main memory, with
// store coalescing, store-to-load forwarding and a flush/empty handshake.
module mem_write_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic [ADDR_W-1:0]             core_addr,
  input  logic [0:WORD_BYTES-1][7:0]    core_wdata,
  input  logic                          core_we,
  input  logic                          core_re,
  output logic [0:WORD_BYTES-1][7:0]    core_rdata,
  output logic                          stall,
  input  logic                          flush,
  output logic                          empty,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [0:WORD_BYTES-1][7:0]    mem_data_in,
  output logic                          mem_write_en,
  input  logic [0:WORD_BYTES-1][7:0]    mem_data_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t               entries_r [DEPTH];
  logic [PTR_W-1:0]        head_r;
  logic [PTR_W-1:0]        tail_r;
  logic [CNT_W-1:0]        count_r;

  logic [ENTRY_ADDR_W-1:0] core_addr_ext_s;
  logic                    rd_hit_s;
  logic [PTR_W-1:0]        rd_idx_s;
  logic                    wr_coal_hit_s;
  logic [PTR_W-1:0]        wr_coal_idx_s;
  logic                    wr_unused_hit_s;
  logic [PTR_W-1:0]        wr_unused_idx_s;
  logic                    rd_unused_coal_hit_s;
  logic [PTR_W-1:0]        rd_unused_coal_idx_s;
  logic                    full_s;
  logic                    base_drain_s;
  logic                    stall_s;
  logic                    drain_s;
  logic                    accept_s;
  logic                    alloc_s;
  logic                    coal_write_s;

  assign core_addr_ext_s = ENTRY_ADDR_W'(core_addr);

  wb_match #(.DEPTH(DEPTH)) u_rd_match (
    .entries      (entries_r),
    .tail         (tail_r),
    .head         (head_r),
    .exclude_head (1'b0),
    .addr         (core_addr_ext_s),
    .hit          (rd_hit_s),
    .youngest_idx (rd_idx_s),
    .coalesce_hit (rd_unused_coal_hit_s),
    .coalesce_idx (rd_unused_coal_idx_s)
  );

  // Head is excluded from coalescing only when it is certain to leave this
  // cycle; a stall-forced drain never coincides with an accepted write.
  wb_match #(.DEPTH(DEPTH)) u_wr_match (
    .entries      (entries_r),
    .tail         (tail_r),
    .head         (head_r),
    .exclude_head (base_drain_s),
    .addr         (core_addr_ext_s),
    .hit          (wr_unused_hit_s),
    .youngest_idx (wr_unused_idx_s),
    .coalesce_hit (wr_coal_hit_s),
    .coalesce_idx (wr_coal_idx_s)
  );

  assign full_s       = (count_r == CNT_W'(DEPTH));
  assign base_drain_s = (count_r != CNT_W'(0)) && (!core_re || flush);
  assign stall_s      = core_we && full_s && !wr_coal_hit_s;
  assign drain_s      = (count_r != CNT_W'(0)) && (base_drain_s || stall_s);
  assign accept_s     = core_we && !stall_s;
  assign alloc_s      = accept_s && !wr_coal_hit_s;
  assign coal_write_s = accept_s && wr_coal_hit_s;

  assign stall        = stall_s;
  assign empty        = (count_r == CNT_W'(0));
  assign mem_write_en = drain_s;
  assign mem_addr     = drain_s ? ADDR_W'(entries_r[head_r].addr) : core_addr;
  assign mem_data_in  = drain_s ? entries_r[head_r].data : byte_word_t'(32'h0);
  assign core_rdata   = rd_hit_s ? entries_r[rd_idx_s].data : mem_data_out;

  // FIFO state: retire at head, allocate at tail, coalesce in place
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= wb_entry_t'(0);
      end
      head_r  <= PTR_W'(0);
      tail_r  <= PTR_W'(0);
      count_r <= CNT_W'(0);
    end else begin
      if (coal_write_s) begin
        entries_r[wr_coal_idx_s].data <= core_wdata;
      end
      if (drain_s) begin
        entries_r[head_r].valid <= 1'b0;
        head_r                  <= head_r + PTR_W'(1);
      end
      if (alloc_s) begin
        entries_r[tail_r] <= '{valid: 1'b1, addr: core_addr_ext_s, data: core_wdata};
        tail_r            <= tail_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(alloc_s) - CNT_W'(drain_s);
    end
  end

endmodule
